// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

  // Width of one datapath slice; the adder walks the operands this many bits per cycle.
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_e;

  // Slice counter width; a one-slice adder still needs a one-bit counter.
  function automatic int nsa_cnt_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// 4-bit ripple-carry adder used as the per-slice datapath of the serial adder.
module nibble_serial_adder_rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] carry;

  // Ripple the carry through four full adders, LSB first.
  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    co = carry[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one 4-bit slice per cycle through a single RCA, LSB slice first.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// RUN   | one slice added per cycle, NSLICE cycles total
// DONE  | result presented (out_valid); may accept next op on handshake
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = nsa_cnt_width(NSLICE);
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  nsa_state_e       state_q,   state_d;
  logic [WIDTH-1:0] op_a_q,    op_a_d;
  logic [WIDTH-1:0] op_b_q,    op_b_d;
  logic             carry_q,   carry_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0] sum_sh_q,  sum_sh_d;
  logic [WIDTH-1:0] sum_q,     sum_d;
  logic             c_out_q,   c_out_d;
  logic             ovf_q,     ovf_d;

  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;
  logic               carry_into_top;
  logic               accept;

  // Operands and partial sum are widened by one slice so the shift is legal even at WIDTH=4.
  logic [WIDTH+SLICE_W-1:0] op_a_ext, op_b_ext, sum_ext;
  logic [WIDTH-1:0]         op_a_shift, op_b_shift, sum_shift;

  nibble_serial_adder_rca u_rca (
    .a  (op_a_q[SLICE_W-1:0]),
    .b  (op_b_q[SLICE_W-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

  // Slice shifting: operands move right, new sum slice enters from the MSB side.
  always_comb begin
    op_a_ext       = {{SLICE_W{1'b0}}, op_a_q};
    op_b_ext       = {{SLICE_W{1'b0}}, op_b_q};
    sum_ext        = {slice_s, sum_sh_q};
    op_a_shift     = op_a_ext[WIDTH+SLICE_W-1:SLICE_W];
    op_b_shift     = op_b_ext[WIDTH+SLICE_W-1:SLICE_W];
    sum_shift      = sum_ext[WIDTH+SLICE_W-1:SLICE_W];
    carry_into_top = op_a_q[SLICE_W-1] ^ op_b_q[SLICE_W-1] ^ slice_s[SLICE_W-1];
  end

  // Next-state and datapath control; result registers only change on the last slice.
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d  = a;
          op_b_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        op_a_d   = op_a_shift;
        op_b_d   = op_b_shift;
        sum_sh_d = sum_shift;
        carry_d  = slice_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_SLICE) begin
          sum_d   = sum_shift;
          c_out_d = slice_co;
          ovf_d   = slice_co ^ carry_into_top;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          op_a_d  = a;
          op_b_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation and clears the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and back-to-back random checks for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; c_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++;
    if ({sum, c_out, ovf} !== 18'h0) begin
      failures++; $display("FAIL reset_outputs got sum=%h c=%b o=%b want 0000/0/0", sum, c_out, ovf);
    end
  endtask

  task automatic test_add_vec(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                              input logic [15:0] es, input logic ec, input logic eo, input string nm);
    int lat;
    @(negedge clk);
    a = ta; b = tb_v; c_in = tc; in_valid = 1'b1; out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL %s_in_ready got=%b want=1", nm, in_ready); end
    @(negedge clk);
    in_valid = 1'b0; a = ~ta; b = 16'h5A5A; c_in = ~tc;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 4) begin failures++; $display("FAIL %s_latency got=%0d want=4", nm, lat); end
    checks++;
    if ({sum, c_out, ovf} !== {es, ec, eo}) begin
      failures++;
      $display("FAIL %s_result got sum=%h c=%b o=%b want sum=%h c=%b o=%b", nm, sum, c_out, ovf, es, ec, eo);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || sum !== es) begin
      failures++; $display("FAIL %s_hold got valid=%b sum=%h want valid=0 sum=%h", nm, out_valid, sum, es);
    end
  endtask

  task automatic test_arith();
    test_add_vec(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "basic");
    test_add_vec(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
    test_add_vec(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf");
    test_add_vec(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1, "neg_ovf");
    test_add_vec(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, "cin_only");
    test_add_vec(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "all_ones");
    test_add_vec(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, "min_minus1");
  endtask

  task automatic test_backpressure();
    int waitc;
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    waitc = 0;
    while (out_valid !== 1'b1 && waitc < 20) begin @(negedge clk); waitc++; end
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_timeout got valid=%b want=1", out_valid); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {sum, c_out, ovf} !== {16'h2345, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL bp_stall%0d got valid=%b rdy=%b sum=%h c=%b o=%b want 1/0/2345/0/0",
                 i, out_valid, in_ready, sum, c_out, ovf);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h2345) begin
      failures++; $display("FAIL bp_release got valid=%b sum=%h want 0/2345", out_valid, sum);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    a = 16'h00FF; b = 16'h0F0F; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {sum, c_out, ovf} !== 18'h0) begin
      failures++;
      $display("FAIL midrst_clear got valid=%b rdy=%b sum=%h c=%b o=%b want 0/1/0000/0/0",
               out_valid, in_ready, sum, c_out, ovf);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || sum !== 16'h0) begin
        failures++; $display("FAIL midrst_stale%0d got valid=%b sum=%h want 0/0000", i, out_valid, sum);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp_q[$];
    logic [17:0] exp_v;
    logic [16:0] full;
    logic [15:0] ra, rb;
    logic        rc;
    int done_ops, cyc, last_acc, n_acc;
    done_ops = 0; cyc = 0; last_acc = -1; n_acc = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (done_ops < 1000 && cyc < 6000) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_unexpected got sum=%h", sum);
        end else begin
          exp_v = exp_q.pop_front();
          if ({sum, c_out, ovf} !== exp_v) begin
            failures++;
            $display("FAIL b2b_op%0d got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                     done_ops, sum, c_out, ovf, exp_v[17:2], exp_v[1], exp_v[0]);
          end
        end
        done_ops++;
      end
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      a = ra; b = rb; c_in = rc;
      if (in_ready === 1'b1) begin
        full = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
        exp_q.push_back({full[15:0], full[16], (ra[15] == rb[15]) && (full[15] != ra[15])});
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 5) begin
            failures++; $display("FAIL b2b_interval got=%0d want=5", cyc - last_acc);
          end
        end
        last_acc = cyc;
        n_acc++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done_ops < 1000) begin failures++; $display("FAIL b2b_timeout got=%0d want=1000", done_ops); end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
